// File: rtl/booth_seq_ctrl_if.sv
// Control bus between operation control (master) and the Booth sequencing FSM (slave).
// op_start is a request taken only while idle; op_done is a level that holds until op_clear.
interface booth_seq_ctrl_if #(
  parameter int CW = 7
);
  logic          op_start;
  logic          op_clear;
  logic          step_stall;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          load_en;
  logic          step_en;
  logic          op_done;
  logic          busy;

  modport master (
    output op_start, op_clear, step_stall,
    input  state, count, load_en, step_en, op_done, busy
  );

  modport slave (
    input  op_start, op_clear, step_stall,
    output state, count, load_en, step_en, op_done, busy
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Four-state sequencer for the Booth multiplier: IDLE -> LOAD -> MUL (ITER steps) -> DONE.
// state/count are registered; strobes are decoded from state and the current inputs.
module booth_seq_ctrl #(
  parameter int WIDTH  = 64,
  parameter int RADIX4 = 0
) (
  input logic              clk,
  input logic              reset_n,
  booth_seq_ctrl_if.slave  bus
);
  localparam int ITER = (RADIX4 != 0) ? WIDTH / 2 : WIDTH;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_C = CW'(ITER - 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_MUL  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else if (bus.op_clear) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          cnt <= '0;
          if (bus.op_start) st <= S_LOAD;
        end
        S_LOAD: begin
          cnt <= '0;
          st  <= S_MUL;
        end
        S_MUL: begin
          // A stalled cycle freezes both the count and the state.
          if (!bus.step_stall) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST_C) st <= S_DONE;
          end
        end
        S_DONE: begin
          cnt <= ITER_C;
        end
        default: begin
          st  <= S_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.count   = cnt;
  assign bus.load_en = (st == S_LOAD) && !bus.op_clear;
  assign bus.step_en = (st == S_MUL) && !bus.step_stall && !bus.op_clear;
  assign bus.op_done = (st == S_DONE);
  assign bus.busy    = (st == S_LOAD) || (st == S_MUL);
endmodule
